// File: rtl/sar_value_finder_pkg.sv
// Shared definitions for the successive-approximation value finder:
// FSM state codes, comparator verdict codes and the worst-case latency.
package sar_value_finder_pkg;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_DRIVE   = 3'd1;
    localparam logic [2:0] ST_SAMPLE  = 3'd2;
    localparam logic [2:0] ST_VDRIVE  = 3'd3;
    localparam logic [2:0] ST_VSAMPLE = 3'd4;
    localparam logic [2:0] ST_DONE    = 3'd5;

    // Verdicts are packed as {L, E, G}.
    localparam logic [2:0] CMP_LT = 3'b100;
    localparam logic [2:0] CMP_EQ = 3'b010;
    localparam logic [2:0] CMP_GT = 3'b001;

    // Cycles from the accepted start to the done pulse for a full search plus verify.
    function automatic int searchLatency(input int width);
        return 2 * width + 3;
    endfunction

endpackage

// File: rtl/sar_value_finder.sv
// MSB-first successive-approximation controller that drives trial words into an
// external magnitude comparator and converges on its hidden unsigned target.
import sar_value_finder_pkg::*;

module sar_value_finder #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             cmp_L,
    input  logic             cmp_E,
    input  logic             cmp_G,
    output logic [WIDTH-1:0] trial,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             found,
    output logic             err,
    output logic [2:0]       stateDbg
);

    localparam int IDXW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IDXW-1:0]  IDX_TOP = IDXW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
    localparam logic [WIDTH-1:0] TOP_BIT = ONE << (WIDTH - 1);

    logic [2:0]       state;
    logic [IDXW-1:0]  idx;
    logic [2:0]       verdict;
    logic             verdictLegal;
    logic [WIDTH-1:0] bitMask;
    logic [WIDTH-1:0] keptTrial;
    logic [WIDTH-1:0] stepTrial;

    assign verdict      = {cmp_L, cmp_E, cmp_G};
    assign verdictLegal = (verdict == CMP_LT) || (verdict == CMP_EQ) || (verdict == CMP_GT);
    assign bitMask      = ONE << idx;
    // A "greater" verdict means the bit under test overshoots; drop it, then probe the next bit down.
    assign keptTrial    = (verdict == CMP_GT) ? (trial & ~bitMask) : trial;
    assign stepTrial    = keptTrial | (bitMask >> 1);
    assign stateDbg     = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            idx    <= IDX_TOP;
            trial  <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
            found  <= 1'b0;
            err    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        trial <= TOP_BIT;
                        idx   <= IDX_TOP;
                        found <= 1'b0;
                        err   <= 1'b0;
                        busy  <= 1'b1;
                        state <= ST_DRIVE;
                    end
                end
                ST_DRIVE: state <= ST_SAMPLE;
                ST_SAMPLE: begin
                    if (!verdictLegal) begin
                        err    <= 1'b1;
                        found  <= 1'b0;
                        result <= '0;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        state  <= ST_DONE;
                    end else if (verdict == CMP_EQ) begin
                        found  <= 1'b1;
                        result <= trial;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        state  <= ST_DONE;
                    end else begin
                        trial <= stepTrial;
                        if (idx != '0) begin
                            idx   <= idx - 1'b1;
                            state <= ST_DRIVE;
                        end else begin
                            state <= ST_VDRIVE;
                        end
                    end
                end
                ST_VDRIVE: state <= ST_VSAMPLE;
                ST_VSAMPLE: begin
                    // The accumulated word is reported either way; found says whether it matched.
                    if (!verdictLegal) begin
                        err    <= 1'b1;
                        found  <= 1'b0;
                        result <= '0;
                    end else begin
                        err    <= 1'b0;
                        found  <= (verdict == CMP_EQ);
                        result <= trial;
                    end
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= ST_DONE;
                end
                ST_DONE: begin
                    trial <= '0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sar_value_finder.sv
// Randomized bench for sar_value_finder: an ideal comparator answers the trials,
// and a scoreboard checks each done pulse against an arithmetic search model.
module tb_sar_value_finder;
    import sar_value_finder_pkg::*;

    localparam int WIDTH = 4;
    localparam int W     = 16 + WIDTH + 2;   // {doneCycle[15:0], result, found, err}

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             cmp_L, cmp_E, cmp_G;
    logic [WIDTH-1:0] trial;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             found;
    logic             err;
    logic [2:0]       stateDbg;

    logic [WIDTH-1:0] target;
    logic             forceOn;
    logic [2:0]       forceVal;

    int checks    = 0;
    int failures  = 0;
    int doneSeen  = 0;
    int cycleCnt  = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] expMon;

    sar_value_finder #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst(rst), .start(start),
        .cmp_L(cmp_L), .cmp_E(cmp_E), .cmp_G(cmp_G),
        .trial(trial), .busy(busy), .done(done), .result(result),
        .found(found), .err(err), .stateDbg(stateDbg)
    );

    // Responder: plain magnitude compare (cascade L=0,E=1,G=0), optionally overridden.
    assign {cmp_L, cmp_E, cmp_G} = forceOn ? forceVal
                                           : {trial < target, trial == target, trial > target};

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cycleCnt <= cycleCnt + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cycleCnt);
        end
    endtask

    // ---------------- reference model ----------------
    // mode 0: honest comparator, 1: illegal {1,1,0}, 2: always "less", 3: always "greater"
    function automatic void model(input logic [WIDTH-1:0] tgt, input int mode, output int lat,
                                  output logic [WIDTH-1:0] res, output logic fnd, output logic er);
        int k;
        lat = searchLatency(WIDTH);
        res = '0;
        fnd = 1'b0;
        er  = 1'b0;
        case (mode)
            1: begin lat = 3; er = 1'b1; end
            2: res = '1;
            3: res = '0;
            default: begin
                res = tgt;
                fnd = 1'b1;
                // The search hits the target exactly when probing its lowest set bit.
                if (tgt != 0) begin
                    k = 0;
                    for (int b = WIDTH - 1; b >= 0; b--) if (tgt[b]) k = b;
                    lat = 2 * (WIDTH - k) + 1;
                end
            end
        endcase
    endfunction

    // ---------------- monitor / scoreboard ----------------
    always @(posedge clk) begin
        #1;
        if (done) begin
            doneSeen++;
            if (exp_q.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                expMon = exp_q.pop_front();
                check("done_cycle", cycleCnt, int'(expMon[W-1 -: 16]));
                check("result", int'(result), int'(expMon[WIDTH+1:2]));
                check("found", int'(found), int'(expMon[1]));
                check("err", int'(err), int'(expMon[0]));
            end
        end
    end

    // ---------------- driver ----------------
    task automatic runSearch(input logic [WIDTH-1:0] tgt, input int mode,
                             input bit rstAt4, input bit repulse);
        int lat, c, base, n;
        logic [WIDTH-1:0] res;
        logic fnd, er;
        n = 0;
        while (stateDbg != ST_IDLE && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("idle_before_start", int'(stateDbg), int'(ST_IDLE));
        @(negedge clk);
        model(tgt, mode, lat, res, fnd, er);
        target   = tgt;
        forceOn  = (mode != 0);
        forceVal = (mode == 1) ? 3'b110 : (mode == 2) ? CMP_LT : CMP_GT;
        start    = 1'b1;
        c        = cycleCnt;
        base     = doneSeen;
        if (!rstAt4) exp_q.push_back({16'(c + lat), res, fnd, er});
        for (int j = 1; j <= lat; j++) begin
            @(negedge clk);
            start = repulse && (j == 2 || j == 5 || j == lat);
            if (j == 1) begin
                check("first_trial", int'(trial), 1 << (WIDTH - 1));
                check("found_cleared", int'(found), 0);
                check("err_cleared", int'(err), 0);
            end
            if (rstAt4 && j == 5) begin
                rst = 1'b0;
                check("rst_state", int'(stateDbg), int'(ST_IDLE));
                check("rst_trial", int'(trial), 0);
                check("rst_busy", int'(busy), 0);
                check("rst_done", int'(done), 0);
                check("rst_result", int'(result), 0);
                break;
            end
            check("busy", int'(busy), int'(j < lat));
            if (rstAt4 && j == 4) rst = 1'b1;
        end
        @(negedge clk);
        start = 1'b0;
        if (rstAt4) begin
            repeat (12) @(negedge clk);
            check("no_done_after_rst", doneSeen, base);
        end else begin
            n = 0;
            while (doneSeen == base && n < 20) begin
                @(negedge clk);
                n++;
            end
            check("done_timeout", int'(doneSeen > base), 1);
        end
        if (repulse) begin
            repeat (3) @(negedge clk);
            check("repulse_idle", int'(stateDbg), int'(ST_IDLE));
            check("repulse_busy", int'(busy), 0);
            check("repulse_one_done", doneSeen, base + 1);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int r;
        rst      = 1'b1;
        start    = 1'b0;
        forceOn  = 1'b0;
        forceVal = 3'b000;
        target   = '0;
        repeat (3) @(negedge clk);
        check("reset_trial", int'(trial), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);
        check("reset_result", int'(result), 0);
        check("reset_found", int'(found), 0);
        check("reset_err", int'(err), 0);
        check("reset_state", int'(stateDbg), int'(ST_IDLE));
        rst = 1'b0;
        @(negedge clk);

        runSearch(4'd6, 0, 1'b0, 1'b0);
        runSearch(4'd15, 0, 1'b0, 1'b0);
        runSearch(4'd0, 0, 1'b0, 1'b0);
        runSearch(4'd3, 1, 1'b0, 1'b0);
        runSearch(4'd7, 0, 1'b0, 1'b0);
        runSearch(4'd9, 0, 1'b1, 1'b0);
        runSearch(4'd9, 0, 1'b0, 1'b0);
        runSearch(4'd5, 0, 1'b0, 1'b1);
        runSearch(4'd10, 2, 1'b0, 1'b0);
        runSearch(4'd10, 3, 1'b0, 1'b0);

        for (int i = 0; i < 30; i++) begin
            r = $urandom_range(0, 9);
            runSearch(WIDTH'($urandom_range(0, (1 << WIDTH) - 1)),
                      (r < 7) ? 0 : r - 6, 1'b0, 1'b0);
        end

        repeat (5) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
